// File: rtl/weight_disp_pkg.sv
// Shared constants, state enum and weight type for the weight bank / bar display path.
package weight_disp_pkg;

  localparam int unsigned NUM_W       = 8;
  localparam int unsigned W_WIDTH     = 10;
  localparam int unsigned MAX_BAR     = 200;
  localparam int unsigned VBLANK_LINE = 480;
  localparam int unsigned BAR_AXIS_Y  = 241;
  localparam int unsigned IDX_WIDTH   = $clog2(NUM_W);
  localparam int unsigned POS_WIDTH   = 10;
  localparam int unsigned CNT_WIDTH   = 8;

  typedef logic signed [W_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Screen row of a bar's tip for a given weight (positive weights grow upward).
  function automatic logic [POS_WIDTH-1:0] bar_tip_y(input weight_t w);
    return POS_WIDTH'(int'(BAR_AXIS_Y) - int'(w));
  endfunction

endpackage

// File: rtl/weight_clamp.sv
// Combinational signed saturator to [-MAX_BAR, +MAX_BAR]; pass-through unless
// WEIGHT_CLAMP_EN is defined.
module weight_clamp
  import weight_disp_pkg::*;
(
  input  weight_t raw,
  output weight_t sat_c
);

`ifdef WEIGHT_CLAMP_EN
  localparam weight_t LIMIT = weight_t'(MAX_BAR);

  always_comb begin
    sat_c = raw;
    if (raw > LIMIT) begin
      sat_c = LIMIT;
    end else if (raw < -LIMIT) begin
      sat_c = -LIMIT;
    end
  end
`else
  assign sat_c = raw;
`endif

endmodule

// File: rtl/weight_frame_scheduler.sv
// Shadow/active weight bank; a complete set is committed only at vertical blank.
// Optional build macro: WEIGHT_CLAMP_EN (saturate written weights to +/-MAX_BAR).
module weight_frame_scheduler
  import weight_disp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [IDX_WIDTH-1:0] wr_index,
  input  weight_t              wr_data,
  input  logic                 wr_last,
  input  logic [POS_WIDTH-1:0] counter_x,
  input  logic [POS_WIDTH-1:0] counter_y,
  output weight_t              step1,
  output weight_t              step2,
  output weight_t              step3,
  output weight_t              step4,
  output weight_t              step5,
  output weight_t              step6,
  output weight_t              step7,
  output weight_t              step8,
  output logic                 commit_pulse,
  output logic [CNT_WIDTH-1:0] commit_count
);

  state_t  state;
  state_t  next_state;
  weight_t shadow [NUM_W];
  weight_t active [NUM_W];
  weight_t wr_sat_c;
  logic    blank_evt_c;
  logic    accept_c;
  logic    commit_c;

  weight_clamp u_clamp (
    .raw   (wr_data),
    .sat_c (wr_sat_c)
  );

  assign blank_evt_c = (counter_x == '0) && (counter_y == POS_WIDTH'(VBLANK_LINE));
  assign accept_c    = wr_valid && wr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // Blank is ignored while collecting so an incomplete set never reaches the display.
  always_comb begin
    next_state = state;
    wr_ready   = 1'b0;
    commit_c   = 1'b0;
    case (state)
      COLLECT: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_last) begin
          next_state = PENDING;
        end
      end
      PENDING: begin
        if (blank_evt_c) begin
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        commit_c   = 1'b1;
        next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_W); i++) begin
        shadow[i] <= '0;
      end
    end else if (accept_c) begin
      shadow[wr_index] <= wr_sat_c;
    end
  end

  // Shadow is kept after commit so a later set may update only some indices.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_W); i++) begin
        active[i] <= '0;
      end
      commit_pulse <= 1'b0;
      commit_count <= '0;
    end else begin
      commit_pulse <= commit_c;
      if (commit_c) begin
        for (int i = 0; i < int'(NUM_W); i++) begin
          active[i] <= shadow[i];
        end
        commit_count <= commit_count + CNT_WIDTH'(1);
      end
    end
  end

  assign step1 = active[0];
  assign step2 = active[1];
  assign step3 = active[2];
  assign step4 = active[3];
  assign step5 = active[4];
  assign step6 = active[5];
  assign step7 = active[6];
  assign step8 = active[7];

endmodule

// File: tb/tb_weight_frame_scheduler.sv
// Directed bench for weight_frame_scheduler with a frame-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_weight_frame_scheduler;
  import weight_disp_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_index = '0;
  weight_t       wr_data = '0;
  logic          wr_last = 1'b0;
  logic [9:0]    counter_x = 10'd5;
  logic [9:0]    counter_y = 10'd100;
  weight_t       step1, step2, step3, step4, step5, step6, step7, step8;
  logic          commit_pulse;
  logic [7:0]    commit_count;

  int errors = 0;
  int checks = 0;

  weight_frame_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_index     (wr_index),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .counter_x    (counter_x),
    .counter_y    (counter_y),
    .step1        (step1),
    .step2        (step2),
    .step3        (step3),
    .step4        (step4),
    .step5        (step5),
    .step6        (step6),
    .step7        (step7),
    .step8        (step8),
    .commit_pulse (commit_pulse),
    .commit_count (commit_count)
  );

  always #5 clock = ~clock;

  weight_t steps [8];
  assign steps[0] = step1;
  assign steps[1] = step2;
  assign steps[2] = step3;
  assign steps[3] = step4;
  assign steps[4] = step5;
  assign steps[5] = step6;
  assign steps[6] = step7;
  assign steps[7] = step8;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampf(input int v);
`ifdef WEIGHT_CLAMP_EN
    if (v > 200) return 200;
    if (v < -200) return -200;
`endif
    return v;
  endfunction

  // Frame-level model: a closed set waits for the next blank, then lands one edge later.
  int  m_shadow [8];
  int  m_active [8];
  int  m_count;
  bit  m_pulse;
  bit  m_set_closed;
  bit  m_landing;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      m_count = 0;
      m_pulse = 0;
      m_set_closed = 0;
      m_landing = 0;
    end else begin
      bit blank;
      blank = (counter_x == 10'd0) && (counter_y == 10'd480);
      if (m_landing) begin
        m_active = m_shadow;
        m_count = (m_count + 1) % 256;
        m_pulse = 1;
        m_landing = 0;
      end else begin
        m_pulse = 0;
        if (m_set_closed) begin
          if (blank) begin
            m_set_closed = 0;
            m_landing = 1;
          end
        end else if (wr_valid) begin
          m_shadow[wr_index] = clampf(int'($signed(wr_data)));
          if (wr_last) m_set_closed = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("wr_ready", int'(wr_ready), int'(!m_set_closed && !m_landing));
      chk("commit_pulse", int'(commit_pulse), int'(m_pulse));
      chk("commit_count", int'(commit_count), m_count);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("step%0d", i + 1), int'($signed(steps[i])), m_active[i]);
      end
    end
  end

  task automatic wr(input int idx, input int val, input bit last);
    wr_valid = 1'b1;
    wr_index = 3'(idx);
    wr_data  = weight_t'(val);
    wr_last  = last;
    @(negedge clock);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic blank();
    counter_x = 10'd0;
    counter_y = 10'd480;
    @(negedge clock);
    counter_x = 10'd5;
    counter_y = 10'd100;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int vals [8];
    vals = '{10, -20, 30, -40, 50, -60, 70, -80};

    // Reset state
    idle(3);
    chk("reset_step1", int'($signed(step1)), 0);
    chk("reset_pulse", int'(commit_pulse), 0);
    chk("reset_count", int'(commit_count), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", int'(wr_ready), 1);

    // Full set then blank
    for (int i = 0; i < 8; i++) wr(i, vals[i], i == 7);
    chk("ready_pending", int'(wr_ready), 0);
    idle(4);
    chk("step1_hold_pending", int'($signed(step1)), 0);
    blank();
    chk("pulse_not_yet", int'(commit_pulse), 0);
    @(negedge clock);
    chk("full_step1", int'($signed(step1)), 10);
    chk("full_step8", int'($signed(step8)), -80);
    chk("full_pulse", int'(commit_pulse), 1);
    chk("full_count", int'(commit_count), 1);
    @(negedge clock);
    chk("pulse_fell", int'(commit_pulse), 0);
    chk("ready_back", int'(wr_ready), 1);

    // Partial set: blank ignored
    for (int i = 0; i < 5; i++) wr(i, i + 1, 1'b0);
    blank();
    idle(3);
    chk("partial_step1", int'($signed(step1)), 10);
    chk("partial_count", int'(commit_count), 1);

    // Clamp boundaries, closing the partial set
    wr(0, 300, 1'b0);
    wr(1, -511, 1'b1);
    blank();
    @(negedge clock);
`ifdef WEIGHT_CLAMP_EN
    chk("clamp_pos", int'($signed(step1)), 200);
    chk("clamp_neg", int'($signed(step2)), -200);
`else
    chk("clamp_pos", int'($signed(step1)), 300);
    chk("clamp_neg", int'($signed(step2)), -511);
`endif
    chk("clamp_step3", int'($signed(step3)), 3);
    chk("clamp_step6", int'($signed(step6)), -60);
    chk("clamp_count", int'(commit_count), 2);
    idle(2);

    // wr_last accepted in the same cycle as blank: commit waits a frame
    counter_x = 10'd0;
    counter_y = 10'd480;
    wr(4, -7, 1'b1);
    counter_x = 10'd5;
    counter_y = 10'd100;
    idle(4);
    chk("simul_count_hold", int'(commit_count), 2);
    chk("simul_step5_hold", int'($signed(step5)), 5);
    chk("simul_ready", int'(wr_ready), 0);
    blank();
    @(negedge clock);
    chk("simul_count", int'(commit_count), 3);
    chk("simul_step5", int'($signed(step5)), -7);
    idle(2);

    // Reset while a set is pending
    wr(3, 77, 1'b1);
    idle(2);
    reset = 1'b1;
    idle(2);
    chk("rst_pend_count", int'(commit_count), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_pend_ready", int'(wr_ready), 1);
    blank();
    idle(3);
    chk("rst_pend_step4", int'($signed(step4)), 0);
    chk("rst_pend_count2", int'(commit_count), 0);

    // 256 commits wrap the counter
    for (int i = 0; i < 256; i++) begin
      wr(0, i, 1'b1);
      blank();
      idle(2);
    end
    chk("wrap_count", int'(commit_count), 0);
`ifdef WEIGHT_CLAMP_EN
    chk("wrap_step1", int'($signed(step1)), 200);
`else
    chk("wrap_step1", int'($signed(step1)), 255);
`endif
    chk("wrap_step2", int'($signed(step2)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
